// File: rtl/seg7_scan_mux.sv
// ============================================================================
// Module  : seg7_scan_mux
// Brief   : 4-digit multiplexed 7-segment driver: frame snapshots, dead-time
//           blanking between slots, optional leading-zero suppression.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_mux #(
    parameter int DIV        = 50000,
    parameter int BLANK      = 64,
    parameter bit LZB_EN     = 1'b1,
    parameter bit SEG_ACT_LO = 1'b1,
    parameter bit AN_ACT_LO  = 1'b1
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic [3:0] iDig0,
    input  logic [3:0] iDig1,
    input  logic [3:0] iDig2,
    input  logic [3:0] iDig3,
    input  logic [3:0] iDp,
    output logic [6:0] oSeg,
    output logic       oDp,
    output logic [3:0] oAn,
    output logic       oFrame
);

    localparam int              CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   c_CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0]   c_BLANK     = CW'(BLANK);
    localparam logic [6:0]      c_SEG_OFF   = SEG_ACT_LO ? 7'h7F : 7'h00;
    localparam logic            c_DP_OFF    = SEG_ACT_LO;
    localparam logic [3:0]      c_AN_OFF    = AN_ACT_LO ? 4'hF : 4'h0;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] shd_q;
    logic [3:0]      shd_dp_q;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;
    logic            frame_q, frame_d;

    logic            slot_end;
    logic [3:0]      lz_blank;
    logic [6:0]      seg_hi;
    logic [3:0]      an_hi;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end = (cnt_q == c_CNT_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        frame_d  = slot_end && (idx_q == 2'd3);

        // A digit is suppressed only when it and every more-significant digit are zero.
        lz_blank[3] = (shd_q[3] == 4'd0);
        lz_blank[2] = lz_blank[3] && (shd_q[2] == 4'd0);
        lz_blank[1] = lz_blank[2] && (shd_q[1] == 4'd0);
        lz_blank[0] = 1'b0;
        lz_blank    = lz_blank & {4{LZB_EN}};

        seg_hi = lz_blank[idx_q] ? 7'h00 : f_decode(shd_q[idx_q]);
        seg_d  = SEG_ACT_LO ? ~seg_hi : seg_hi;
        dp_d   = shd_dp_q[idx_q] ^ SEG_ACT_LO;

        an_hi  = (cnt_q >= c_BLANK) ? (4'b0001 << idx_q) : 4'b0000;
        an_d   = AN_ACT_LO ? ~an_hi : an_hi;
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shd_q    <= '0;
            shd_dp_q <= 4'h0;
            seg_q    <= c_SEG_OFF;
            dp_q     <= c_DP_OFF;
            an_q     <= c_AN_OFF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            if (frame_d) begin
                shd_q    <= {iDig3, iDig2, iDig1, iDig0};
                shd_dp_q <= iDp;
            end
        end
    end

    assign oSeg   = seg_q;
    assign oDp    = dp_q;
    assign oAn    = an_q;
    assign oFrame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
// ============================================================================
// Module  : tb_seg7_scan_mux
// Brief   : Directed bench for seg7_scan_mux (DIV=8, BLANK=2), LZB on and off.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_mux;

    logic       iclk = 1'b0;
    logic       ireset;
    logic [3:0] iDig0, iDig1, iDig2, iDig3, iDp;
    logic [6:0] oSeg_l, oSeg_n;
    logic       oDp_l, oDp_n, oFrame_l, oFrame_n;
    logic [3:0] oAn_l, oAn_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 iclk = ~iclk;

    seg7_scan_mux #(.DIV(8), .BLANK(2), .LZB_EN(1'b1), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1)) u_dut_lzb (
        .iclk(iclk), .ireset(ireset),
        .iDig0(iDig0), .iDig1(iDig1), .iDig2(iDig2), .iDig3(iDig3), .iDp(iDp),
        .oSeg(oSeg_l), .oDp(oDp_l), .oAn(oAn_l), .oFrame(oFrame_l)
    );

    seg7_scan_mux #(.DIV(8), .BLANK(2), .LZB_EN(1'b0), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1)) u_dut_nolzb (
        .iclk(iclk), .ireset(ireset),
        .iDig0(iDig0), .iDig1(iDig1), .iDig2(iDig2), .iDig3(iDig3), .iDp(iDp),
        .oSeg(oSeg_n), .oDp(oDp_n), .oAn(oAn_n), .oFrame(oFrame_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                          input logic [3:0] d0, input logic [3:0] dp);
        iDig3 = d3; iDig2 = d2; iDig1 = d1; iDig0 = d0; iDp = dp;
    endtask

    // Called when the scan sits at cnt=0, idx=0; walks one 32-cycle frame.
    // Segment patterns are packed {slot3, slot2, slot1, slot0}; dp_e bit k is oDp in slot k.
    task automatic scan(input logic [27:0] seg_l_e, input logic [27:0] seg_n_e,
                        input logic [3:0] dp_e, input logic [3:0] mid_d0);
        for (int c = 1; c <= 32; c++) begin
            int         k;
            int         pos;
            logic [3:0] an_e;
            @(negedge iclk);
            if (c == 16) iDig0 = mid_d0;
            k    = (c - 1) / 8;
            pos  = (c - 1) % 8;
            an_e = (pos < 2) ? 4'hF : ~(4'b0001 << k);
            chk("an_lzb",    {28'd0, oAn_l}, {28'd0, an_e});
            chk("an_nolzb",  {28'd0, oAn_n}, {28'd0, an_e});
            chk("seg_lzb",   {25'd0, oSeg_l}, {25'd0, seg_l_e[7*k +: 7]});
            chk("seg_nolzb", {25'd0, oSeg_n}, {25'd0, seg_n_e[7*k +: 7]});
            chk("dp",        {31'd0, oDp_l}, {31'd0, dp_e[k]});
            chk("frame",     {31'd0, oFrame_l}, {31'd0, (c == 32)});
        end
    endtask

    initial begin
        ireset = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'h0);
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        ireset = 1'b1;
        chk("rst_an",    {28'd0, oAn_l}, 32'hF);
        chk("rst_seg",   {25'd0, oSeg_l}, 32'h7F);
        chk("rst_dp",    {31'd0, oDp_l}, 32'h1);
        chk("rst_frame", {31'd0, oFrame_l}, 32'h0);

        // Frame 0 shows the reset snapshot (zeros) while 1234 waits to be latched.
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'h0);
        scan({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'd4);

        set_in(4'd0, 4'd0, 4'd0, 4'd7, 4'h0);
        scan({7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'd7);

        // Value 0007; units input changes mid-frame and must stay invisible.
        set_in(4'd0, 4'hC, 4'd0, 4'd5, 4'b0100);
        scan({7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h78}, 4'hF, 4'd9);

        // Snapshot 0C09 with dp on digit 2: dash, no suppression below it.
        set_in(4'd0, 4'd0, 4'd5, 4'd0, 4'b1000);
        scan({7'h7F, 7'h3F, 7'h40, 7'h10}, {7'h40, 7'h3F, 7'h40, 7'h10}, 4'b1011, 4'd0);

        // Snapshot 0050 with dp lit on the blanked thousands digit.
        set_in(4'd8, 4'd8, 4'd8, 4'd8, 4'h0);
        scan({7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111, 4'd8);

        // Reset in the middle of slot 2.
        repeat (19) @(negedge iclk);
        chk("slot2_an", {28'd0, oAn_l}, 32'hB);
        ireset = 1'b0;
        @(negedge iclk);
        chk("mid_rst_an",    {28'd0, oAn_l}, 32'hF);
        chk("mid_rst_seg",   {25'd0, oSeg_l}, 32'h7F);
        chk("mid_rst_frame", {31'd0, oFrame_l}, 32'h0);
        ireset = 1'b1;
        scan({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'd8);

        for (int i = 0; i < 1000; i++) begin
            @(negedge iclk);
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            ireset = ($urandom_range(0, 49) != 0);
            chk("onehot_lzb",   {31'd0, ($countones(~oAn_l) <= 1)}, 32'h1);
            chk("onehot_nolzb", {31'd0, ($countones(~oAn_n) <= 1)}, 32'h1);
        end
        ireset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
